// File: rtl/btn_debounce_pulse_if.sv
// Button-conditioning bus: raw button in, debounced level, edge strobes and press count out.
interface btn_debounce_pulse_if #(
    parameter int COUNT_W = 8
);
    logic               btn_in;
    logic               btn_level;
    logic               rise_pulse;
    logic               fall_pulse;
    logic [COUNT_W-1:0] press_count;

    modport master (output btn_in, input btn_level, rise_pulse, fall_pulse, press_count);
    modport slave  (input btn_in, output btn_level, rise_pulse, fall_pulse, press_count);
endinterface

// File: rtl/btn_debounce_pulse.sv
// Synchronizes a bouncy button, qualifies it with a stability FSM, and emits a
// clean level, one-cycle rise/fall strobes and a wrapping press counter.
module btn_debounce_pulse #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int COUNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    btn_debounce_pulse_if.slave    bus
);
    localparam int            CW   = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {LOW, WAIT_HIGH, HIGH, WAIT_LOW} state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    state_t                 state, nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic                   level_d, rise_d, fall_d;
    logic                   level_q, rise_q, fall_q;
    logic [COUNT_W-1:0]     press_q;

    // btn_in enters the design only through this chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '0;
        else     sync <= {sync[SYNC_STAGES-2:0], bus.btn_in};
    end
    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOW;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        case (state)
            LOW: if (s) begin
                nxt     = WAIT_HIGH;
                cnt_nxt = '0;
            end
            WAIT_HIGH: begin
                if (!s) begin
                    nxt     = LOW;
                    cnt_nxt = '0;
                end else if (cnt == LAST) nxt = HIGH;
                else                      cnt_nxt = cnt + 1'b1;
            end
            HIGH: if (!s) begin
                nxt     = WAIT_LOW;
                cnt_nxt = '0;
            end
            WAIT_LOW: begin
                if (s) begin
                    nxt     = HIGH;
                    cnt_nxt = '0;
                end else if (cnt == LAST) nxt = LOW;
                else                      cnt_nxt = cnt + 1'b1;
            end
            default: begin
                nxt     = LOW;
                cnt_nxt = '0;
            end
        endcase
    end

    // Outputs are computed from the next state so they land on the accepting edge
    assign rise_d  = (state == WAIT_HIGH) && (nxt == HIGH);
    assign fall_d  = (state == WAIT_LOW)  && (nxt == LOW);
    assign level_d = (nxt == HIGH) || (nxt == WAIT_LOW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            press_q <= '0;
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            if (rise_d) press_q <= press_q + 1'b1;
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.rise_pulse  = rise_q;
    assign bus.fall_pulse  = fall_q;
    assign bus.press_count = press_q;
endmodule

// File: doc/btn_debounce_pulse.md
Name: btn_debounce_pulse

Overview:
- Input-conditioning stage that sits directly upstream of the lab's D flip-flop capture stages.
- Takes a raw, asynchronous, bouncy push-button or switch signal and passes it through a multi-flop synchronizer.
- Qualifies the signal with a stability counter and state machine, then presents a clean level.
- Also provides single-cycle rise/fall strobes and a wrap-around press counter for downstream registers.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops (legal >= 2).
- STABLE_CYCLES, 4, consecutive clk cycles the synchronized input must hold a new value before it is accepted (legal >= 1; board builds use 1000000).
- COUNT_W, 8, width of press counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn_in  input  1  raw asynchronous button input.
- btn_level  output  1  debounced level.
- rise_pulse  output  1  one-cycle strobe on accepted 0->1.
- fall_pulse  output  1  one-cycle strobe on accepted 1->0.
- press_count  output  COUNT_W  number of accepted rising edges, modulo 2^COUNT_W.

Behaviour:
- Reset: rst high clears all of the following immediately, without waiting for clk:
  - synchronizer flops to 0;
  - FSM to LOW;
  - stability counter to 0;
  - btn_level, rise_pulse and fall_pulse to 0;
  - press_count to 0.
- Synchronizer: a chain of SYNC_STAGES flops; s is the last stage. btn_in is used nowhere else.
- Stability counter: width clog2(STABLE_CYCLES)+1.
- FSM states: LOW, WAIT_HIGH, HIGH, WAIT_LOW.
  - LOW (btn_level=0): if s=1, go to WAIT_HIGH with cnt<=0.
  - WAIT_HIGH (btn_level=0):
    - if s=0, go to LOW with cnt<=0 (glitch rejected, no pulse);
    - else if cnt==STABLE_CYCLES-1, go to HIGH;
    - else cnt<=cnt+1.
  - HIGH (btn_level=1): if s=0, go to WAIT_LOW with cnt<=0.
  - WAIT_LOW (btn_level=1): mirror of WAIT_HIGH with the polarity swapped; returns to HIGH on s=1.
- Outputs are registered.
  - btn_level, rise_pulse and press_count update on the same edge the FSM enters HIGH.
  - rise_pulse is high for exactly one clk cycle. It is cleared on the next edge.
  - fall_pulse behaves the same way on entry to LOW from WAIT_LOW.
  - rise_pulse and fall_pulse are never high together.
- Latency: btn_in goes high cleanly and is first sampled at edge 1. btn_level and rise_pulse go high after edge SYNC_STAGES+STABLE_CYCLES+1. With the defaults that is edge 7, i.e. 7 cycles. Falling-edge latency is identical.
- Bounce: any reversion of s during a WAIT state restarts qualification from the stable state. Accepting a change needs STABLE_CYCLES+1 consecutive samples of the new value, counting the entry sample.
- press_count wraps from 2^COUNT_W-1 to 0 on the next accepted rise. There is no saturation flag.
- STABLE_CYCLES=1: the WAIT state is held exactly one cycle, so the level is accepted on the second consecutive sample.
- Reset mid-operation:
  - Any WAIT progress is discarded.
  - If btn_in is still high after rst deasserts, the block requalifies from LOW with full latency.
  - That requalification produces a rise_pulse and counts as a press.
- Reset deassertion is synchronous to clk in the bench. No pulse is emitted on reset entry or exit by itself.

Test Plan:
1. Reset and steady high: rst=1 for 25 ns with btn_in=1, then release; clk period 20 ns -> btn_level stays 0 for 6 edges, then btn_level=1 and rise_pulse=1 for one cycle at edge 7; press_count=1.
2. Clean press/release, defaults: btn_in 0->1 held 200 ns, then 1->0 -> rise_pulse at edge 7 after the rise; fall_pulse one cycle exactly 7 edges after the fall; press_count=1; no overlap of pulses.
3. Bounce rejection: btn_in toggles high/low every 30 ns for 5 toggles, then settles high -> btn_level only rises 7 edges after the final settle; exactly one rise_pulse; press_count increments by 1.
4. Short glitch: btn_in high for 3 cycles (less than 4 stable) then low -> btn_level stays 0, no pulses, press_count unchanged.
5. Counter wrap: with COUNT_W=2, apply 5 clean presses -> press_count sequence 1,2,3,0,1.
6. Reset mid-WAIT: assert rst asynchronously (not on a clk edge) 2 cycles into WAIT_HIGH -> all outputs 0 within the same time step; after release with btn_in still high, the full 7-edge qualification repeats and one rise_pulse is seen.
